// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU command arbiter and its helpers.
package alu_ctrl_pkg;

    localparam int CMD_W = 12;
    localparam logic [2:0] OP_CAS = 3'b111;

    // Command field positions: op | a1 | a2 | a3
    localparam int OP_MSB = 11;
    localparam int OP_LSB = 9;
    localparam int A1_MSB = 8;
    localparam int A1_LSB = 6;
    localparam int A2_MSB = 5;
    localparam int A2_LSB = 3;
    localparam int A3_MSB = 2;
    localparam int A3_LSB = 0;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_ISSUE   = 2'd1,
        ARB_WAIT    = 2'd2,
        ARB_RESPOND = 2'd3
    } arb_state_t;

    function automatic logic is_cas(input logic [CMD_W-1:0] cmd);
        return cmd[OP_MSB:OP_LSB] == OP_CAS;
    endfunction

endpackage

// File: rtl/alu_cmd_arbiter_rr_picker.sv
// Rotating-priority encoder: first set request at or after ptr (mod N) wins.
module rr_picker #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] id,
    output logic            any
);

    logic [ID_W-1:0] idx;

    // Scan from the pointer upward with wrap; the first hit takes the grant.
    always_comb begin
        gnt = '0;
        id  = '0;
        any = 1'b0;
        idx = '0;
        for (int k = 0; k < N; k++) begin
            idx = ID_W'((int'(ptr) + k) % N);
            if (!any && req[idx]) begin
                gnt[idx] = 1'b1;
                id       = idx;
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_cmd_arbiter.sv
// Round-robin arbiter sharing one register-file/ALU controller among N
// requesters: accept a command, pulse syscall, wait out the controller's
// fixed sequence, then hand the r7 snapshot back to the winner.
module alu_cmd_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int N           = 4,
    parameter int ID_W        = (N > 1) ? $clog2(N) : 1,
    parameter int HOLD_CYCLES = 5,
    parameter int MAX_LOCK    = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N-1:0]        req_valid,
    input  logic [N*CMD_W-1:0]  req_cmd,
    input  logic [N-1:0]        req_lock,
    output logic [N-1:0]        req_ready,
    output logic [CMD_W-1:0]    cmd_out,
    output logic                syscall_out,
    input  logic [31:0]         r7_in,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [ID_W-1:0]     resp_id,
    output logic [31:0]         resp_data,
    output logic                resp_cas,
    output logic                busy
);

    localparam int CNT_W  = $clog2(HOLD_CYCLES + 1);
    localparam int LOCK_W = $clog2(MAX_LOCK + 1);

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [CMD_W-1:0]  cmd_q, cmd_d;
    logic [ID_W-1:0]   win_id_q, win_id_d;
    logic              cas_q, cas_d;
    logic              resp_valid_q, resp_valid_d;
    logic [ID_W-1:0]   resp_id_q, resp_id_d;
    logic [31:0]       resp_data_q, resp_data_d;
    logic              resp_cas_q, resp_cas_d;

    logic [N-1:0]      pick_gnt;
    logic [ID_W-1:0]   pick_id;
    logic              pick_any;
    logic [CMD_W-1:0]  cmd_arr [N];

    rr_picker #(
        .N    (N),
        .ID_W (ID_W)
    ) u_picker (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt),
        .id  (pick_id),
        .any (pick_any)
    );

    for (genvar i = 0; i < N; i++) begin : g_cmd
        assign cmd_arr[i] = req_cmd[i*CMD_W +: CMD_W];
    end

    // Next-state, counter, latch and pointer logic for the arbitration FSM.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rr_ptr_d     = rr_ptr_q;
        lock_cnt_d   = lock_cnt_q;
        cmd_d        = cmd_q;
        win_id_d     = win_id_q;
        cas_d        = cas_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_data_d  = resp_data_q;
        resp_cas_d   = resp_cas_q;

        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    cmd_d    = cmd_arr[pick_id];
                    win_id_d = pick_id;
                    cas_d    = is_cas(cmd_arr[pick_id]);
                    state_d  = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                cnt_d   = CNT_W'(HOLD_CYCLES - 1);
                state_d = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (cnt_q == '0) begin
                    resp_valid_d = 1'b1;
                    resp_data_d  = r7_in;
                    resp_id_d    = win_id_q;
                    resp_cas_d   = cas_q;
                    state_d      = ARB_RESPOND;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ARB_RESPOND: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = ARB_IDLE;
                    // A locking winner keeps priority up to MAX_LOCK grants in a row.
                    if (req_lock[win_id_q] && (lock_cnt_q < LOCK_W'(MAX_LOCK - 1))) begin
                        rr_ptr_d   = win_id_q;
                        lock_cnt_d = lock_cnt_q + 1'b1;
                    end else begin
                        rr_ptr_d   = (win_id_q == ID_W'(N - 1)) ? '0 : win_id_q + 1'b1;
                        lock_cnt_d = '0;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any command in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            cnt_q        <= '0;
            rr_ptr_q     <= '0;
            lock_cnt_q   <= '0;
            cmd_q        <= '0;
            win_id_q     <= '0;
            cas_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_data_q  <= '0;
            resp_cas_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rr_ptr_q     <= rr_ptr_d;
            lock_cnt_q   <= lock_cnt_d;
            cmd_q        <= cmd_d;
            win_id_q     <= win_id_d;
            cas_q        <= cas_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
            resp_cas_q   <= resp_cas_d;
        end
    end

    // The accept strobe is combinational and must be silent while reset is held.
    assign req_ready   = (state_q == ARB_IDLE && rst_n) ? pick_gnt : '0;
    assign syscall_out = (state_q == ARB_ISSUE);
    assign cmd_out     = cmd_q;
    assign busy        = (state_q != ARB_IDLE);
    assign resp_valid  = resp_valid_q;
    assign resp_id     = resp_id_q;
    assign resp_data   = resp_data_q;
    assign resp_cas    = resp_cas_q;

endmodule

// File: tb/tb_alu_cmd_arbiter.sv
// Bench for alu_cmd_arbiter: directed scenarios plus randomized traffic,
// all checked against a cycle-timed transaction model.
module tb_alu_cmd_arbiter;

    localparam int N        = 4;
    localparam int MAX_LOCK = 3;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  req_valid;
    logic [N*12-1:0] req_cmd;
    logic [N-1:0]  req_lock;
    logic [N-1:0]  req_ready;
    logic [11:0]   cmd_out;
    logic          syscall_out;
    logic [31:0]   r7_in;
    logic          resp_valid;
    logic          resp_ready;
    logic [1:0]    resp_id;
    logic [31:0]   resp_data;
    logic          resp_cas;
    logic          busy;

    alu_cmd_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_cmd     (req_cmd),
        .req_lock    (req_lock),
        .req_ready   (req_ready),
        .cmd_out     (cmd_out),
        .syscall_out (syscall_out),
        .r7_in       (r7_in),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_data   (resp_data),
        .resp_cas    (resp_cas),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int          glog[$];
    int          rid_log[$];
    logic [31:0] rdata_log[$];
    logic        rcas_log[$];
    logic        m_inflight;
    int          m_k;
    int          m_id;
    logic [11:0] m_cmd;
    logic        m_cas;
    logic [31:0] m_data;
    int          m_ptr;
    int          m_lockrun;

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Transaction model: accept in cycle A means syscall in A+1, r7 captured
    // at the end of A+6, response visible from A+7 until accepted.
    initial begin
        int          w;
        logic [N-1:0] exp_rdy;
        m_inflight = 1'b0; m_k = 0; m_id = 0; m_cmd = '0; m_cas = 1'b0;
        m_data = '0; m_ptr = 0; m_lockrun = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_inflight = 1'b0; m_ptr = 0; m_lockrun = 0;
                chk("rst_ready",   64'(req_ready),   64'(0));
                chk("rst_busy",    64'(busy),        64'(0));
                chk("rst_syscall", 64'(syscall_out), 64'(0));
                chk("rst_rvalid",  64'(resp_valid),  64'(0));
                chk("rst_cmd",     64'(cmd_out),     64'(0));
                chk("rst_rid",     64'(resp_id),     64'(0));
                chk("rst_rdata",   64'(resp_data),   64'(0));
                chk("rst_rcas",    64'(resp_cas),    64'(0));
            end else if (!m_inflight) begin
                w = pick(req_valid, m_ptr);
                exp_rdy = (w >= 0) ? N'(1 << w) : '0;
                chk("idle_ready",   64'(req_ready),   64'(exp_rdy));
                chk("idle_busy",    64'(busy),        64'(0));
                chk("idle_syscall", 64'(syscall_out), 64'(0));
                chk("idle_rvalid",  64'(resp_valid),  64'(0));
                if (w >= 0) begin
                    m_inflight = 1'b1;
                    m_k        = 0;
                    m_id       = w;
                    m_cmd      = req_cmd[w*12 +: 12];
                    m_cas      = (m_cmd[11:9] == 3'b111);
                    glog.push_back(w);
                end
            end else begin
                m_k++;
                chk("fl_ready",   64'(req_ready),   64'(0));
                chk("fl_busy",    64'(busy),        64'(1));
                chk("fl_syscall", 64'(syscall_out), 64'(m_k == 1));
                if (m_k == 1) chk("fl_cmd_out", 64'(cmd_out), 64'(m_cmd));
                if (m_k == 6) m_data = r7_in;
                chk("fl_rvalid", 64'(resp_valid), 64'(m_k >= 7));
                if (m_k >= 7) begin
                    chk("resp_id",   64'(resp_id),   64'(m_id));
                    chk("resp_data", 64'(resp_data), 64'(m_data));
                    chk("resp_cas",  64'(resp_cas),  64'(m_cas));
                    if (resp_ready) begin
                        rid_log.push_back(m_id);
                        rdata_log.push_back(m_data);
                        rcas_log.push_back(m_cas);
                        if (req_lock[m_id] && m_lockrun < MAX_LOCK - 1) begin
                            m_ptr = m_id;
                            m_lockrun++;
                        end else begin
                            m_ptr = (m_id + 1) % N;
                            m_lockrun = 0;
                        end
                        m_inflight = 1'b0;
                    end
                end
            end
        end
    end

    // Stimulus
    logic [N-1:0] keep_valid;
    logic         rand_mode;

    task automatic step();
        logic [N-1:0] acc;
        @(negedge clk);
        acc = req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                if (keep_valid[i]) req_cmd[i*12 +: 12] = 12'($urandom);
                else req_valid[i] = 1'b0;
            end
        end
        if (rand_mode) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    req_valid[i] = 1'b1;
                    req_cmd[i*12 +: 12] = 12'($urandom);
                end
            end
            req_lock   = N'($urandom);
            resp_ready = ($urandom_range(0, 3) != 0);
            r7_in      = $urandom;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    task automatic wait_grants(input string tag, input int target, input int budget);
        int c = 0;
        while (glog.size() < target && c < budget) begin step(); c++; end
        chk(tag, 64'(glog.size() >= target), 64'(1));
    endtask

    task automatic wait_resp(input string tag, input int target, input int budget);
        int c = 0;
        while (rid_log.size() < target && c < budget) begin step(); c++; end
        chk(tag, 64'(rid_log.size() >= target), 64'(1));
    endtask

    task automatic drain();
        int c = 0;
        req_valid  = '0;
        keep_valid = '0;
        resp_ready = 1'b1;
        while (busy && c < 60) begin step(); c++; end
        chk("drain_busy", 64'(busy), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int rbase;
        int c;
        int rr_exp[5];
        int lk_exp[5];
        rr_exp = '{0, 1, 2, 3, 0};
        lk_exp = '{0, 1, 1, 1, 2};

        rst_n = 1'b0; req_valid = '0; req_cmd = '0; req_lock = '0;
        resp_ready = 1'b0; r7_in = '0; keep_valid = '0; rand_mode = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;

        // Single request from requester 2
        req_cmd[2*12 +: 12] = 12'h0D1; req_valid = 4'b0100; r7_in = 32'h55; resp_ready = 1'b1;
        base = glog.size(); rbase = rid_log.size();
        wait_resp("single_tmo", rbase + 1, 30);
        if (glog.size() > base)        chk("single_grant", 64'(glog[base]), 64'(2));
        if (rid_log.size() > rbase) begin
            chk("single_rid",   64'(rid_log[rbase]),   64'(2));
            chk("single_rdata", 64'(rdata_log[rbase]), 64'(32'h55));
            chk("single_rcas",  64'(rcas_log[rbase]),  64'(0));
        end

        // Idle gap
        req_valid = '0;
        repeat (20) begin
            step();
            chk("gap_busy",    64'(busy),        64'(0));
            chk("gap_syscall", 64'(syscall_out), 64'(0));
            chk("gap_ready",   64'(req_ready),   64'(0));
        end

        // Round-robin fairness
        do_reset();
        for (int i = 0; i < N; i++) req_cmd[i*12 +: 12] = 12'($urandom);
        req_lock = '0; resp_ready = 1'b1; keep_valid = '1; req_valid = '1;
        base = glog.size();
        wait_grants("rr_tmo", base + 5, 100);
        for (int i = 0; i < 5; i++)
            if (glog.size() > base + i) chk($sformatf("rr_grant%0d", i), 64'(glog[base + i]), 64'(rr_exp[i]));
        drain();

        // Lock cap
        do_reset();
        req_lock = 4'b0010; resp_ready = 1'b1; keep_valid = '1; req_valid = '1;
        base = glog.size();
        wait_grants("lock_tmo", base + 5, 100);
        for (int i = 0; i < 5; i++)
            if (glog.size() > base + i) chk($sformatf("lock_grant%0d", i), 64'(glog[base + i]), 64'(lk_exp[i]));
        req_lock = '0;
        drain();

        // CAS tag with response backpressure
        do_reset();
        for (int i = 0; i < 3; i++) req_cmd[i*12 +: 12] = 12'($urandom);
        req_cmd[3*12 +: 12] = 12'hE53; req_valid = 4'b1000; resp_ready = 1'b0; r7_in = 32'hCAFE_0003;
        base = glog.size(); rbase = rid_log.size();
        wait_grants("cas_tmo", base + 1, 20);
        if (glog.size() > base) chk("cas_grant", 64'(glog[base]), 64'(3));
        req_valid = req_valid | 4'b0111;
        c = 0;
        while (!resp_valid && c < 30) begin step(); c++; end
        chk("cas_rvalid", 64'(resp_valid), 64'(1));
        repeat (10) begin
            step();
            chk("cas_hold_valid", 64'(resp_valid), 64'(1));
            chk("cas_hold_flag",  64'(resp_cas),   64'(1));
            chk("cas_hold_id",    64'(resp_id),    64'(3));
            chk("cas_hold_ready", 64'(req_ready),  64'(0));
        end
        resp_ready = 1'b1;
        wait_resp("cas_resp_tmo", rbase + 1, 10);
        req_valid = '0;
        if (rid_log.size() > rbase) chk("cas_rcas", 64'(rcas_log[rbase]), 64'(1));
        drain();

        // Reset in the middle of WAIT
        do_reset();
        req_cmd[0 +: 12] = 12'h123; req_valid = 4'b0001; resp_ready = 1'b1;
        c = 0;
        while (!syscall_out && c < 20) begin step(); c++; end
        chk("mw_syscall", 64'(syscall_out), 64'(1));
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        chk("mw_busy",    64'(busy),        64'(0));
        chk("mw_syscall0", 64'(syscall_out), 64'(0));
        chk("mw_rvalid",  64'(resp_valid),  64'(0));
        chk("mw_ready",   64'(req_ready),   64'(0));
        chk("mw_cmd",     64'(cmd_out),     64'(0));
        chk("mw_rdata",   64'(resp_data),   64'(0));
        chk("mw_rid",     64'(resp_id),     64'(0));
        chk("mw_rcas",    64'(resp_cas),    64'(0));
        req_valid = 4'b0100;
        step(); step();
        rst_n = 1'b1;
        base = glog.size();
        wait_grants("mw_grant_tmo", base + 1, 20);
        if (glog.size() > base) chk("mw_grant", 64'(glog[base]), 64'(2));
        drain();

        // Randomized traffic
        rand_mode = 1'b1; keep_valid = '0;
        base = glog.size();
        repeat (600) step();
        rand_mode = 1'b0;
        drain();
        chk("rand_progress", 64'(glog.size() > base + 10), 64'(1));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_cmd_arbiter.md
Name: alu_cmd_arbiter

Overview:
- Shares the single register-file/ALU command controller among N requesters.
- Each requester offers a 12-bit command (op[11:9], a1[8:6], a2[5:3], a3[2:0]; op 3'b111 = CAS) with a valid/ready handshake.
- The arbiter picks one requester round-robin, issues the command as a one-cycle syscall pulse, and waits out the controller's fixed sequence.
- It then returns the register-7 snapshot to the winner on a response channel, tagged with the requester id.

Parameters:
- N, 4, number of requesters (2..8).
- ID_W, $clog2(N), requester id width.
- HOLD_CYCLES, 5, cycles from syscall pulse until controller is back in IDLE and r7 is stable (>=2).
- MAX_LOCK, 3, maximum consecutive grants a locking requester may hold.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N  per-requester command valid.
- req_cmd  in  N*12  packed commands; requester i at [12*i+11:12*i].
- req_lock  in  N  requester wants the next grant as well (atomic sequence).
- req_ready  out  N  one-hot accept strobe.
- cmd_out  out  12  command to controller.
- syscall_out  out  1  run pulse to controller.
- r7_in  in  32  controller register_out_7.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response accepted.
- resp_id  out  ID_W  requester that owns the response.
- resp_data  out  32  r7 snapshot.
- resp_cas  out  1  response belongs to a CAS command.
- busy  out  1  arbiter not in IDLE.

Behaviour:
- Reset, asynchronous, any state: state=IDLE, rr_ptr=0, lock_cnt=0, cmd_out=0, syscall_out=0, req_ready=0, resp_valid=0, resp_id=0, resp_data=0, resp_cas=0, busy=0.
- States: IDLE, ISSUE, WAIT, RESPOND.
- IDLE:
  - Winner = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... mod N.
  - req_ready[winner]=1 combinationally in that cycle; the handshake completes there.
  - Edge: latch cmd, winner id, cas=(op==3'b111); go to ISSUE.
  - No valid requester: stay in IDLE, req_ready=0.
- ISSUE (1 cycle):
  - cmd_out=latched cmd, syscall_out=1.
  - Load cnt=HOLD_CYCLES-1; go to WAIT.
  - cmd_out holds the latched cmd until the next ISSUE.
- WAIT:
  - Decrement cnt each cycle.
  - When cnt==0: register resp_data<=r7_in, resp_valid<=1; go to RESPOND.
  - Syscall-to-resp_valid latency is exactly HOLD_CYCLES+1 cycles.
- RESPOND:
  - Hold resp_valid, resp_id, resp_data, resp_cas stable until resp_valid&&resp_ready.
  - On the handshake edge: resp_valid<=0, go to IDLE, update the pointer (below).
- Pointer update:
  - If req_lock[winner]==1 at the handshake and lock_cnt<MAX_LOCK-1: rr_ptr=winner, lock_cnt++.
  - Otherwise: rr_ptr=(winner+1) mod N, lock_cnt=0.
  - The lock is a priority hint only. A locked requester that drops valid forfeits; the next valid requester in scan order wins.
- At most one command in flight. req_ready stays 0 outside IDLE.
- Requesters must hold req_cmd stable while req_valid is high.
- busy = (state!=IDLE).
- Reset mid-operation:
  - The command in flight is abandoned, with no response.
  - syscall_out drops immediately.
  - The controller is owned by the surrounding system and is not reset by this block.
- N=1: rr_ptr is always 0; the lock only affects lock_cnt.

Decomposition:
- Shared package alu_ctrl_pkg:
  - arb_state_t enum.
  - CMD_W=12, OP_CAS=3'b111.
  - Command field slice constants.
- Sub-module rr_picker (combinational rotate-priority encoder: req vector + pointer -> one-hot grant + id + any).
- FSM, counter and response registers stay in the top.

Test Plan:
- Single request: req_valid[2]=1, cmd=12'h0D1, r7_in=32'h55.
  - Required: req_ready[2] pulses in the same cycle; syscall_out for 1 cycle with cmd_out=12'h0D1.
  - Required: resp_valid 6 cycles after the syscall, resp_id=2, resp_data=32'h55, resp_cas=0.
- Round-robin fairness: all 4 requesters valid continuously, resp_ready=1, no lock.
  - Required: grant order 0,1,2,3,0.
- Lock cap: req_lock[1]=1 and all requesters valid, MAX_LOCK=3.
  - Required: grants 0,1,1,1,2 (requester 1 capped at three consecutive grants).
- CAS tag and backpressure: requester 3 issues cmd=12'hE53; resp_ready held 0 for 10 cycles.
  - Required: resp_cas=1; resp fields stable throughout; no new req_ready until the handshake.
- Reset mid-WAIT: assert rst_n=0 during WAIT.
  - Required: all outputs zero asynchronously.
  - Required: after release with requester 2 valid, a grant to requester 2 occurs (rr_ptr=0 scan).
- Idle gap: no valid for 20 cycles.
  - Required: busy=0, syscall_out=0, req_ready=0 throughout.
